// File: rtl/fetch_prefetch_queue_if.sv
// Fetch unit handshakes: redirect, memory request/response channel and decode-side output.
// master = prefetch queue, slave = surrounding core/memory.
interface fetch_prefetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int OCC_W = 3
);
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [XLEN-1:0]  mem_req_addr;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rsp_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [OCC_W-1:0] occupancy;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, occupancy
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// In-order instruction prefetcher: word fetches into a DEPTH-entry {pc, instr} FIFO for decode.
// Latency: memory response cycle t -> out_valid at t+1; accept to out_valid >= 2 cycles.
// Backpressure: requests are credit-limited by free FIFO slots and MAX_OUTSTANDING; out_ready stalls the head.
module fetch_prefetch_queue #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] stale;
    logic [OCC_W-1:0] occ;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             req_vld;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic             accept;
    logic             rsp_take;
    logic             push;
    logic             pop;
    logic             has_head;
    logic [XLEN-1:0]  redirect_base;
    logic [OUT_W-1:0] outstanding_nxt;
    logic [OUT_W-1:0] stale_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic [31:0]      credit_nxt;
    logic             req_vld_nxt;
    logic             unused_redirect_lsbs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign has_head      = (occ != '0);
    assign accept        = req_vld & bus.mem_req_ready;
    // A response with nothing outstanding is a protocol error; drop it rather than corrupt the counters.
    assign rsp_take      = bus.mem_rsp_valid & (outstanding != '0);
    assign push          = rsp_take & (stale == '0) & ~bus.redirect_valid;
    assign pop           = has_head & bus.out_ready;
    assign redirect_base = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_comb begin
        outstanding_nxt = outstanding + OUT_W'(accept) - OUT_W'(rsp_take);
        stale_nxt       = stale;
        occ_nxt         = occ;
        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            stale_nxt = outstanding_nxt;
            occ_nxt   = '0;
        end else begin
            stale_nxt = stale - OUT_W'(rsp_take && (stale != '0));
            occ_nxt   = occ + OCC_W'(push) - OCC_W'(pop);
        end
        // Free slots must cover every live (non-stale) request before another may issue.
        credit_nxt  = 32'(occ_nxt) + 32'(outstanding_nxt) - 32'(stale_nxt);
        req_vld_nxt = (32'(outstanding_nxt) < 32'(MAX_OUTSTANDING)) && (credit_nxt < 32'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            occ         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            req_vld     <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            stale       <= stale_nxt;
            occ         <= occ_nxt;
            req_vld     <= req_vld_nxt;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= bus.mem_rsp_data;
        end
    end

    assign bus.mem_req_valid = req_vld;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.out_valid     = has_head;
    assign bus.out_pc        = has_head ? pc_mem[rd_ptr] : '0;
    assign bus.out_instr     = has_head ? instr_mem[rd_ptr] : '0;
    assign bus.occupancy     = occ;

    rsp_without_request: assert property (@(posedge clock) disable iff (!reset)
        !(bus.mem_rsp_valid && (outstanding == '0)));

    occupancy_bound: assert property (@(posedge clock) disable iff (!reset)
        (32'(occ) <= 32'(DEPTH)) && (32'(outstanding) <= 32'(MAX_OUTSTANDING)));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: latency-programmable in-order memory model plus an output scoreboard.
module tb_fetch_prefetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } pend_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_prefetch_queue_if #(.XLEN(XLEN), .OCC_W(OCC_W)) bus ();

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          lat    = 1;
    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] acc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc);
        return exp_t'{pc, mem_word(pc)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Memory responder and scoreboard: decisions for the coming rising edge are made on the falling edge.
    task automatic mem_and_monitor();
        exp_t  e;
        pend_t p;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                pend_q.delete();
                bus.mem_req_ready = 1'b0;
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = '0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_extra: got pc=%h instr=%h, required no output", bus.out_pc, bus.out_instr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                            errors++;
                            $display("FAIL out_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                                     bus.out_pc, bus.out_instr, e.pc, e.instr);
                        end
                    end
                end
                if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                    p = pend_q.pop_front();
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(p.addr);
                end else begin
                    bus.mem_rsp_valid = 1'b0;
                    bus.mem_rsp_data  = '0;
                end
                bus.mem_req_ready = 1'b1;
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    acc_log.push_back(bus.mem_req_addr);
                    pend_q.push_back(pend_t'{bus.mem_req_addr, cyc + lat});
                end
            end
        end
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        lat                = 1;
        exp_q.delete();
        acc_log.delete();
        tick(2);
        reset = 1'b1;
    endtask

    // Drive a redirect; a pop handshaking in the same cycle still belongs to the old stream.
    task automatic retarget(input logic [31:0] pc, input int n);
        exp_t keep;
        bit   hs;
        hs = bus.out_valid && bus.out_ready && (exp_q.size() != 0);
        if (hs) keep = exp_q[0];
        exp_q.delete();
        if (hs) exp_q.push_back(keep);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_exp({pc[31:2], 2'b00} + 32'(4 * i)));
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
    endtask

    task automatic test_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        tick(2);
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, required 0", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h, required 00000000", bus.mem_req_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h, required 0", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h, required 0", bus.out_instr); end
        checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d, required 0", bus.occupancy); end
        reset = 1'b1;
        tick(1);
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b, required 1", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr: got %h, required 00000000", bus.mem_req_addr); end
    endtask

    task automatic test_stream();
        int gaps;
        int first;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_exp(32'(4 * i)));
        gaps  = 0;
        first = -1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            tick(1);
            if (bus.out_valid) begin
                if (first < 0) first = i;
            end else if (first >= 0 && exp_q.size() != 0) begin
                gaps++;
            end
        end
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left, required 0", exp_q.size()); end
        checks++; if (first != 2) begin errors++; $display("FAIL stream_first_valid: got cycle %0d, required 2", first); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d, required 0", gaps); end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(12);
        checks++; if (acc_log.size() != 4) begin errors++; $display("FAIL bp_accepts: got %0d, required 4", acc_log.size()); end
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_addr%0d: got %h, required %h", i, acc_log[i], 32'(4 * i)); end
            end
        end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b, required 0", bus.mem_req_valid); end
        checks++; if (bus.occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d, required 4", bus.occupancy); end
        for (int i = 0; i < 6; i++) exp_q.push_back(mk_exp(32'(4 * i)));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d left, required 0", exp_q.size()); end
        checks++;
        if (acc_log.size() < 5 || acc_log[4] !== 32'h10) begin
            errors++; $display("FAIL bp_resume: got %0d accepts, required 5th at 00000010", acc_log.size());
        end
    endtask

    task automatic test_stale_discard();
        int occ_bad;
        do_reset();
        lat           = 3;
        bus.out_ready = 1'b1;
        exp_q.push_back(mk_exp(32'h0));
        exp_q.push_back(mk_exp(32'h4));
        for (int i = 0; i < 40 && acc_log.size() < 4; i++) tick(1);
        checks++;
        if (acc_log.size() != 4 || acc_log[2] !== 32'h8 || acc_log[3] !== 32'hC) begin
            errors++; $display("FAIL stale_setup: got %0d accepts, required 4 ending 8,C", acc_log.size());
        end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_credit: got req_valid %b, required 0", bus.mem_req_valid); end
        retarget(32'h200, 3);
        tick(1);
        bus.redirect_valid = 1'b0;
        occ_bad = 0;
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            if (bus.occupancy !== 3'd0) occ_bad++;
            tick(1);
        end
        checks++; if (occ_bad != 0) begin errors++; $display("FAIL stale_occ: got %0d nonzero cycles, required 0", occ_bad); end
        checks++; if (bus.out_pc !== 32'h200) begin errors++; $display("FAIL stale_first_pc: got %h, required 00000200", bus.out_pc); end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stale_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_exp(32'(4 * i)));
        tick(8);
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL simul_req_valid: got %b, required 1", bus.mem_req_valid); end
        n = acc_log.size();
        retarget(32'h103, 8);
        tick(1);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.mem_req_addr !== 32'h100) begin errors++; $display("FAIL simul_addr: got %h, required 00000100", bus.mem_req_addr); end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL simul_drain: %0d left, required 0", exp_q.size()); end
        checks++;
        if (acc_log.size() < n + 2 || acc_log[n + 1] !== 32'h100) begin
            errors++; $display("FAIL simul_refetch: got %0d accepts, required refetch at 00000100", acc_log.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat           = 2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk_exp(32'(4 * i)));
        tick(6);
        retarget(32'h300, 4);
        tick(1);
        retarget(32'h402, 4);
        tick(1);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.mem_req_addr !== 32'h400) begin errors++; $display("FAIL b2b_addr: got %h, required 00000400", bus.mem_req_addr); end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1);
        retarget(32'hFFFF_FFF8, 4);
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat = 3;
        for (int i = 0; i < 40 && acc_log.size() < 4; i++) tick(1);
        checks++; if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL arst_setup_occ: got %0d, required 2", bus.occupancy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL arst_occ: got %0d, required 0", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL arst_out_data: got pc=%h instr=%h, required 0", bus.out_pc, bus.out_instr); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL arst_req_valid: got %b, required 0", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL arst_req_addr: got %h, required 00000000", bus.mem_req_addr); end
        @(posedge clock);
        #1;
        exp_q.delete();
        acc_log.delete();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(32'(4 * i)));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        bus.out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arst_drain: %0d left, required 0", exp_q.size()); end
        checks++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h0) begin
            errors++; $display("FAIL arst_first_addr: got %0d accepts, required first at 00000000", acc_log.size());
        end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        fork
            mem_and_monitor();
        join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_stale_discard();
        test_simultaneous();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
